// File: rtl/ov7670_sccb_config_if.sv
// Signal bundle between the OV7670 configuration sequencer, its register LUT,
// the SCCB pins and the capture path status inputs.
interface ov7670_sccb_config_if;
  logic        reconfig;
  logic [7:0]  lut_index;
  logic [15:0] lut_data;
  logic        sccb_scl;
  logic        sccb_sda_oe;
  logic        busy;
  logic        config_done;

  modport master (
    input  reconfig,
    input  lut_data,
    output lut_index,
    output sccb_scl,
    output sccb_sda_oe,
    output busy,
    output config_done
  );

  modport slave (
    output reconfig,
    output lut_data,
    input  lut_index,
    input  sccb_scl,
    input  sccb_sda_oe,
    input  busy,
    input  config_done
  );
endinterface

// File: rtl/ov7670_sccb_config.sv
// OV7670 power-up sequencer: walks the register LUT and issues one 3-phase SCCB
// write {DEV_ADDR, reg_addr, reg_data} per entry on open-drain SCL/SDA.
module ov7670_sccb_config #(
  parameter int          CLK_FREQ      = 25_000_000,
  parameter int          SCCB_FREQ     = 100_000,
  parameter int          LUT_SIZE      = 164,
  parameter logic [7:0]  DEV_ADDR      = 8'h42,
  parameter int          PWRUP_DLY_CYC = 25_000
) (
  input  logic                        clk,
  input  logic                        rst,
  ov7670_sccb_config_if.master        bus
);

  localparam int QTR = CLK_FREQ / (4 * SCCB_FREQ);
  localparam int QW  = (QTR > 1) ? $clog2(QTR) : 1;
  localparam int PW  = (PWRUP_DLY_CYC > 1) ? $clog2(PWRUP_DLY_CYC) : 1;

  localparam logic [QW-1:0] QTR_LAST  = QW'(QTR - 1);
  localparam logic [PW-1:0] PWR_LAST  = PW'(PWRUP_DLY_CYC - 1);
  localparam logic [7:0]    IDX_LAST  = 8'(LUT_SIZE - 1);
  localparam logic [4:0]    SLOT_LAST = 5'd26;
  localparam logic [3:0]    X_SLOT    = 4'd8;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PWRUP = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_START = 3'd3;
  localparam logic [2:0] S_BITS  = 3'd4;
  localparam logic [2:0] S_STOP  = 3'd5;
  localparam logic [2:0] S_GAP   = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  logic [2:0]    state_q, state_d;
  logic [QW-1:0] qcnt_q,  qcnt_d;
  logic [1:0]    phase_q, phase_d;
  logic [4:0]    slot_q,  slot_d;
  logic [3:0]    sub_q,   sub_d;
  logic [23:0]   shift_q, shift_d;
  logic [PW-1:0] pwr_q,   pwr_d;
  logic [7:0]    idx_q,   idx_d;
  logic          scl_q,   scl_d;
  logic          oe_q,    oe_d;

  logic running;
  logic tick;

  assign running = (state_q == S_START) || (state_q == S_BITS) ||
                   (state_q == S_STOP)  || (state_q == S_GAP);
  assign tick    = running && (qcnt_q == QTR_LAST);

  always_comb begin
    state_d = state_q;
    qcnt_d  = '0;
    phase_d = phase_q;
    slot_d  = slot_q;
    sub_d   = sub_q;
    shift_d = shift_q;
    pwr_d   = pwr_q;
    idx_d   = idx_q;
    scl_d   = 1'b1;
    oe_d    = 1'b0;

    if (running && !tick) begin
      qcnt_d = qcnt_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        pwr_d   = '0;
        state_d = S_PWRUP;
      end
      S_PWRUP: begin
        if (pwr_q == PWR_LAST) begin
          state_d = S_LOAD;
        end else begin
          pwr_d = pwr_q + 1'b1;
        end
      end
      S_LOAD: begin
        // lut_index has been stable for at least a cycle, so lut_data is settled
        shift_d = {DEV_ADDR, bus.lut_data};
        slot_d  = '0;
        sub_d   = '0;
        phase_d = '0;
        state_d = S_START;
      end
      S_START: begin
        if (tick) begin
          phase_d = phase_q + 2'd1;
          if (phase_q == 2'd3) begin
            state_d = S_BITS;
          end
        end
      end
      S_BITS: begin
        if (tick) begin
          phase_d = phase_q + 2'd1;
          if (phase_q == 2'd3) begin
            // X slots consume no data, so the shifter only advances after real bits
            if (sub_q != X_SLOT) begin
              shift_d = {shift_q[22:0], 1'b0};
            end
            sub_d = (sub_q == X_SLOT) ? 4'd0 : sub_q + 4'd1;
            if (slot_q == SLOT_LAST) begin
              state_d = S_STOP;
            end else begin
              slot_d = slot_q + 5'd1;
            end
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          phase_d = phase_q + 2'd1;
          if (phase_q == 2'd3) begin
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (tick) begin
          phase_d = phase_q + 2'd1;
          if (phase_q == 2'd3) begin
            if (idx_q == IDX_LAST) begin
              state_d = S_DONE;
            end else begin
              idx_d   = idx_q + 8'd1;
              state_d = S_LOAD;
            end
          end
        end
      end
      S_DONE: begin
        if (bus.reconfig) begin
          idx_d   = '0;
          state_d = S_LOAD;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Pin levels are decoded from next-state so they register glitch-free
    case (state_d)
      S_START: begin
        scl_d = (phase_d != 2'd3);
        oe_d  = (phase_d != 2'd0);
      end
      S_BITS: begin
        scl_d = (phase_d == 2'd1) || (phase_d == 2'd2);
        oe_d  = (sub_d != X_SLOT) && !shift_d[23];
      end
      S_STOP: begin
        scl_d = (phase_d != 2'd0);
        oe_d  = !phase_d[1];
      end
      default: begin
        scl_d = 1'b1;
        oe_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      qcnt_q  <= '0;
      phase_q <= '0;
      slot_q  <= '0;
      sub_q   <= '0;
      shift_q <= '0;
      pwr_q   <= '0;
      idx_q   <= '0;
      scl_q   <= 1'b1;
      oe_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      qcnt_q  <= qcnt_d;
      phase_q <= phase_d;
      slot_q  <= slot_d;
      sub_q   <= sub_d;
      shift_q <= shift_d;
      pwr_q   <= pwr_d;
      idx_q   <= idx_d;
      scl_q   <= scl_d;
      oe_q    <= oe_d;
    end
  end

  assign bus.lut_index   = idx_q;
  assign bus.sccb_scl    = scl_q;
  assign bus.sccb_sda_oe = oe_q;
  assign bus.busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus.config_done = (state_q == S_DONE);

endmodule

// File: tb/tb_ov7670_sccb_config.sv
// Directed bench: decodes SCCB frames from the open-drain pins and checks data,
// bus timing, completion, reconfig, ACK insensitivity and mid-frame reset.
module tb_ov7670_sccb_config;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ov7670_sccb_config_if bus ();

  ov7670_sccb_config #(
    .CLK_FREQ      (4_000_000),
    .SCCB_FREQ     (100_000),
    .LUT_SIZE      (3),
    .DEV_ADDR      (8'h42),
    .PWRUP_DLY_CYC (100)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (bus.lut_index)
      8'd0:    bus.lut_data = 16'h1214;
      8'd1:    bus.lut_data = 16'h3a04;
      8'd2:    bus.lut_data = 16'h40d0;
      default: bus.lut_data = 16'h0000;
    endcase
  end

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc++;

  // Bus monitor state
  int          start_cyc[$];
  logic [26:0] frames[$];
  int          stop_cnt   = 0;
  int          viol_cnt   = 0;
  int          done_rises = 0;
  int          per_min    = 1000;
  int          per_max    = 0;
  int          nbits      = 27;
  int          byte_bits  = 0;
  int          last_rise  = 0;
  logic [26:0] cur        = '0;
  logic        ack_en     = 1'b0;
  logic        ack_pull   = 1'b0;
  logic        prev_scl   = 1'b1;
  logic        prev_sda   = 1'b1;
  logic        prev_done  = 1'b0;
  logic        sda_line;

  always @(negedge clk) begin
    sda_line = ~(bus.sccb_sda_oe | ack_pull);
    if (rst) begin
      nbits     = 27;
      byte_bits = 0;
      ack_pull  = 1'b0;
      prev_scl  = 1'b1;
      prev_sda  = 1'b1;
      prev_done = 1'b0;
    end else begin
      if (prev_scl && bus.sccb_scl && prev_sda && !sda_line) begin
        start_cyc.push_back(cyc);
        nbits     = 0;
        byte_bits = 0;
        cur       = '0;
      end else if (prev_scl && bus.sccb_scl && !prev_sda && sda_line) begin
        stop_cnt++;
        if (nbits == 27) begin
          frames.push_back(cur);
          $display("frame %0d: %02h %02h %02h at cycle %0d", frames.size() - 1,
                   cur[26:19], cur[17:10], cur[8:1], cyc);
        end
        nbits = 27;
      end
      if (!prev_scl && bus.sccb_scl && nbits < 27) begin
        if (nbits > 0) begin
          if (cyc - last_rise < per_min) per_min = cyc - last_rise;
          if (cyc - last_rise > per_max) per_max = cyc - last_rise;
        end
        last_rise = cyc;
        cur       = {cur[25:0], sda_line};
        nbits++;
        byte_bits = (byte_bits == 8) ? 0 : byte_bits + 1;
      end
      if (prev_scl && bus.sccb_scl && (prev_sda != sda_line) &&
          !(prev_sda && !sda_line) && !(!prev_sda && sda_line && nbits == 27)) begin
        viol_cnt++;
      end
      // Pull SDA low (ACK) across the X slot, switching only while SCL is low
      if (prev_scl && !bus.sccb_scl) begin
        ack_pull = ack_en && (byte_bits == 8) && (nbits < 27);
      end
      if (bus.config_done && !prev_done) done_rises++;
      prev_scl  = bus.sccb_scl;
      prev_sda  = sda_line;
      prev_done = bus.config_done;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] frame24(input logic [26:0] f);
    return {f[26:19], f[17:10], f[8:1]};
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic pulse_reconfig();
    bus.reconfig = 1'b1;
    step();
    bus.reconfig = 1'b0;
  endtask

  task automatic wait_starts(input int n, input int max_cyc, input string tag);
    int k = 0;
    while (start_cyc.size() < n && k < max_cyc) begin
      step();
      k++;
    end
    check(tag, 32'(start_cyc.size() >= n), 32'd1);
  endtask

  task automatic wait_done(input int max_cyc, input string tag);
    int   k = 0;
    logic pb;
    pb = bus.busy;
    while (!bus.config_done && k < max_cyc) begin
      pb = bus.busy;
      step();
      k++;
    end
    check({tag, "_reached"}, 32'(bus.config_done), 32'd1);
    check({tag, "_busy_fall"}, {31'd0, pb, bus.busy}, 32'b10);
    check({tag, "_idx"}, 32'(bus.lut_index), 32'd2);
  endtask

  task automatic check_pass(input int fb, input string tag);
    check({tag, "_nframes"}, 32'(frames.size()), 32'(fb + 3));
    check({tag, "_f0"}, 32'(frame24(frames[fb])),     32'h421214);
    check({tag, "_f1"}, 32'(frame24(frames[fb + 1])), 32'h423a04);
    check({tag, "_f2"}, 32'(frame24(frames[fb + 2])), 32'h4240d0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rel;
    int sb;
    int fb;
    logic idle_ok;

    bus.reconfig = 1'b0;
    rst          = 1'b1;
    repeat (3) step();

    // Reset state
    check("rst_scl",  32'(bus.sccb_scl),    32'd1);
    check("rst_oe",   32'(bus.sccb_sda_oe), 32'd0);
    check("rst_idx",  32'(bus.lut_index),   32'd0);
    check("rst_busy", 32'(bus.busy),        32'd0);
    check("rst_done", 32'(bus.config_done), 32'd0);

    // Pass 1: power-up wait with a stray reconfig, then the full table
    rst = 1'b0;
    rel = cyc;
    idle_ok = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      idle_ok &= bus.sccb_scl & ~bus.sccb_sda_oe;
      if (i == 50) begin
        check("pwrup_busy", 32'(bus.busy), 32'd1);
        pulse_reconfig();
      end
    end
    check("pwrup_idle", 32'(idle_ok), 32'd1);
    wait_starts(1, 300, "p1_start_seen");
    check("p1_first_start", 32'(start_cyc[0] - rel), 32'd112);
    wait_done(5000, "p1_done");
    check_pass(0, "p1");
    check("p1_stops",    32'(stop_cnt), 32'd3);
    check("p1_gap01",    32'(start_cyc[1] - start_cyc[0]), 32'd1201);
    check("p1_gap12",    32'(start_cyc[2] - start_cyc[1]), 32'd1201);
    check("scl_per_min", 32'(per_min), 32'd40);
    check("scl_per_max", 32'(per_max), 32'd40);
    check("p1_viol",     32'(viol_cnt), 32'd0);
    check("p1_rises",    32'(done_rises), 32'd1);
    repeat (60) step();
    check("done_hold",   32'(bus.config_done), 32'd1);
    check("done_scl",    32'(bus.sccb_scl), 32'd1);
    check("done_oe",     32'(bus.sccb_sda_oe), 32'd0);
    check("done_starts", 32'(start_cyc.size()), 32'd3);

    // Pass 2: reconfig from DONE, with an ignored reconfig mid-frame
    sb = start_cyc.size();
    fb = frames.size();
    rel = cyc;
    pulse_reconfig();
    check("rc_done_clr", 32'(bus.config_done), 32'd0);
    check("rc_busy",     32'(bus.busy), 32'd1);
    check("rc_idx",      32'(bus.lut_index), 32'd0);
    wait_starts(sb + 1, 100, "p2_start_seen");
    check("p2_first_start", 32'(start_cyc[sb] - rel), 32'd12);
    wait_starts(sb + 2, 2000, "p2_second_seen");
    repeat (200) step();
    pulse_reconfig();
    wait_done(5000, "p2_done");
    check_pass(fb, "p2");
    check("p2_starts", 32'(start_cyc.size()), 32'(sb + 3));
    check("p2_rises",  32'(done_rises), 32'd2);
    check("p2_viol",   32'(viol_cnt), 32'd0);

    // Pass 3: sensor ACKs every byte
    ack_en = 1'b1;
    sb = start_cyc.size();
    fb = frames.size();
    pulse_reconfig();
    wait_done(5000, "p3_done");
    ack_en = 1'b0;
    check_pass(fb, "p3");
    check("p3_gap01", 32'(start_cyc[sb + 1] - start_cyc[sb]), 32'd1201);
    check("p3_gap12", 32'(start_cyc[sb + 2] - start_cyc[sb + 1]), 32'd1201);
    check("p3_rises", 32'(done_rises), 32'd3);

    // Pass 4: reset while frame 1 is shifting bits
    sb = start_cyc.size();
    pulse_reconfig();
    wait_starts(sb + 2, 2000, "p4_second_seen");
    repeat (300) step();
    check("p4_idx_before", 32'(bus.lut_index), 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_scl",  32'(bus.sccb_scl),    32'd1);
    check("midrst_oe",   32'(bus.sccb_sda_oe), 32'd0);
    check("midrst_idx",  32'(bus.lut_index),   32'd0);
    check("midrst_busy", 32'(bus.busy),        32'd0);
    repeat (3) step();
    rst = 1'b0;
    rel = cyc;
    sb = start_cyc.size();
    fb = frames.size();
    wait_starts(sb + 1, 300, "p4_restart_seen");
    check("p4_restart_delay", 32'(start_cyc[sb] - rel), 32'd112);
    wait_done(5000, "p4_done");
    check_pass(fb, "p4");
    check("p4_viol", 32'(viol_cnt), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
